// File: rtl/hazard_scoreboard.sv
// Register-busy scoreboard for an in-order pipeline: tracks in-flight writes with a
// per-register countdown until the result becomes forwardable, and raises ID stalls.
module hazard_scoreboard (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic        issue_regwrite_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [1:0]  issue_lat_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic        use_rs1_i,
  input  logic        use_rs2_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic [31:0] pending_o,
  output logic [15:0] stall_cnt_o
);

  logic [31:0] busy_w;
  logic [1:0]  cnt_w [32];
  logic        issue_acc;
  logic        wb_acc;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // x0 is hardwired: never busy, never counting.
  assign busy_w[0] = 1'b0;
  assign cnt_w[0]  = 2'd0;

  assign rs1_busy_o = use_rs1_i && (rs1_i != 5'd0) && busy_w[rs1_i] && (cnt_w[rs1_i] != 2'd0);
  assign rs2_busy_o = use_rs2_i && (rs2_i != 5'd0) && busy_w[rs2_i] && (cnt_w[rs2_i] != 2'd0);
  assign stall_o    = (rs1_busy_o || rs2_busy_o) && !flush_i;

  assign issue_acc = issue_valid_i && issue_regwrite_i && (issue_rd_i != 5'd0) && !stall_o && !flush_i;
  assign wb_acc    = wb_valid_i && (wb_rd_i != 5'd0);

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
      logic       busy_q, busy_d;
      logic [1:0] cnt_q, cnt_d;

      // Issue takes priority over a same-cycle writeback to the same register.
      always_comb begin
        busy_d = busy_q;
        cnt_d  = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
        if (issue_acc && (issue_rd_i == 5'(gi))) begin
          busy_d = 1'b1;
          cnt_d  = issue_lat_i;
        end else if (wb_acc && (wb_rd_i == 5'(gi))) begin
          busy_d = 1'b0;
          cnt_d  = 2'd0;
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          busy_q <= 1'b0;
          cnt_q  <= 2'd0;
        end else begin
          busy_q <= busy_d;
          cnt_q  <= cnt_d;
        end
      end

      assign busy_w[gi] = busy_q;
      assign cnt_w[gi]  = cnt_q;
    end
  endgenerate

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt_q <= 16'd0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign pending_o   = busy_w;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, ALU, multi-cycle, collision, x0,
// flush, asynchronous reset and stall-counter saturation.
module tb_hazard_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i, issue_regwrite_i;
  logic [4:0]  issue_rd_i;
  logic [1:0]  issue_lat_i;
  logic [4:0]  rs1_i, rs2_i;
  logic        use_rs1_i, use_rs2_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic        stall_o, rs1_busy_o, rs2_busy_o;
  logic [31:0] pending_o;
  logic [15:0] stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  hazard_scoreboard dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_regwrite_i(issue_regwrite_i),
    .issue_rd_i(issue_rd_i), .issue_lat_i(issue_lat_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .pending_o(pending_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle();
    issue_valid_i = 0; issue_regwrite_i = 0; issue_rd_i = 0; issue_lat_i = 0;
    rs1_i = 0; rs2_i = 0; use_rs1_i = 0; use_rs2_i = 0;
    wb_valid_i = 0; wb_rd_i = 0; flush_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] lat);
    issue_valid_i = 1; issue_regwrite_i = 1; issue_rd_i = rd; issue_lat_i = lat;
  endtask

  initial begin
    idle();
    rst_i = 1;
    #2;
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    check("reset_pending", pending_o, 32'd0);
    check("reset_stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
    tick();
    rst_i = 0;

    // Load-use: one stall cycle.
    issue(5'd5, 2'd1); #1;
    check("lu_issue_nostall", {31'd0, stall_o}, 32'd0);
    tick(); idle();
    use_rs1_i = 1; rs1_i = 5'd5; #1;
    check("lu_stall", {31'd0, stall_o}, 32'd1);
    check("lu_rs1_busy", {31'd0, rs1_busy_o}, 32'd1);
    check("lu_pending", pending_o, 32'h0000_0020);
    tick();
    check("lu_stall_done", {31'd0, stall_o}, 32'd0);
    check("lu_stall_cnt", {16'd0, stall_cnt_o}, 32'd1);
    idle(); wb_valid_i = 1; wb_rd_i = 5'd5;
    tick(); idle(); #1;
    check("lu_wb_clear", pending_o, 32'd0);

    // ALU dependency: forwardable, no stall, pending until writeback.
    issue(5'd7, 2'd0);
    tick(); idle();
    use_rs2_i = 1; rs2_i = 5'd7; #1;
    check("alu_nostall", {31'd0, stall_o}, 32'd0);
    check("alu_rs2_busy", {31'd0, rs2_busy_o}, 32'd0);
    check("alu_pending", pending_o, 32'h0000_0080);
    tick();
    check("alu_pending_hold", pending_o, 32'h0000_0080);
    idle(); wb_valid_i = 1; wb_rd_i = 5'd7;
    tick(); idle(); #1;
    check("alu_wb_clear", pending_o, 32'd0);

    // Multi-cycle lat=3: three stalls, blocked issue of r10 not recorded.
    issue(5'd9, 2'd3);
    tick(); idle();
    use_rs1_i = 1; rs1_i = 5'd9; use_rs2_i = 1; rs2_i = 5'd9;
    issue(5'd10, 2'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mc_stall_%0d", i), {31'd0, stall_o}, 32'd1);
      tick();
    end
    #1;
    check("mc_stall_end", {31'd0, stall_o}, 32'd0);
    idle();
    check("mc_pending", pending_o, 32'h0000_0200);
    check("mc_stall_cnt", {16'd0, stall_cnt_o}, 32'd4);
    wb_valid_i = 1; wb_rd_i = 5'd9;
    tick(); idle();

    // Collision: issue wins over same-cycle writeback; re-issue reloads countdown.
    issue(5'd4, 2'd0);
    tick(); idle();
    issue(5'd4, 2'd2); wb_valid_i = 1; wb_rd_i = 5'd4;
    tick(); idle();
    use_rs1_i = 1; rs1_i = 5'd4; #1;
    check("col_pending", pending_o, 32'h0000_0010);
    check("col_stall_reload", {31'd0, stall_o}, 32'd1);
    tick(); #1;
    check("col_stall_2", {31'd0, stall_o}, 32'd1);
    tick(); #1;
    check("col_stall_end", {31'd0, stall_o}, 32'd0);
    check("col_stall_cnt", {16'd0, stall_cnt_o}, 32'd6);
    idle(); wb_valid_i = 1; wb_rd_i = 5'd4;
    tick(); idle();

    // x0 is never tracked.
    issue(5'd0, 2'd3);
    tick(); idle();
    use_rs1_i = 1; rs1_i = 5'd0; #1;
    check("x0_pending", pending_o, 32'd0);
    check("x0_nostall", {31'd0, stall_o}, 32'd0);
    idle();

    // Flush masks stall and blocks issue.
    issue(5'd12, 2'd3);
    tick(); idle();
    use_rs1_i = 1; rs1_i = 5'd12; #1;
    check("fl_hazard", {31'd0, stall_o}, 32'd1);
    flush_i = 1; issue(5'd13, 2'd2); #1;
    check("fl_stall_masked", {31'd0, stall_o}, 32'd0);
    tick(); idle(); #1;
    check("fl_pending", pending_o, 32'h0000_1000);
    check("fl_stall_cnt", {16'd0, stall_cnt_o}, 32'd6);

    // Asynchronous reset mid-stall (r12 cnt is 2 here).
    use_rs1_i = 1; rs1_i = 5'd12; #1;
    check("rst_pre_stall", {31'd0, stall_o}, 32'd1);
    rst_i = 1; #1;
    check("rst_async_stall", {31'd0, stall_o}, 32'd0);
    check("rst_async_pending", pending_o, 32'd0);
    check("rst_async_cnt", {16'd0, stall_cnt_o}, 32'd0);
    idle();
    tick();
    rst_i = 0;
    issue(5'd3, 2'd1);
    tick(); idle(); #1;
    check("rst_first_edge", pending_o, 32'h0000_0008);
    use_rs1_i = 1; rs1_i = 5'd3; #1;
    check("rst_first_stall", {31'd0, stall_o}, 32'd1);
    tick(); idle();

    // Saturation: bursts of three stalls per accepted lat=3 issue.
    for (int w = 0; w < 21846; w++) begin
      idle(); issue(5'd1, 2'd3);
      tick();
      idle(); use_rs1_i = 1; rs1_i = 5'd1;
      tick(); tick(); tick();
      if (w == 99)
        check("sat_mid", {16'd0, stall_cnt_o}, 32'd301);
    end
    idle(); #1;
    check("sat_hold", {16'd0, stall_cnt_o}, 32'h0000_FFFF);
    issue(5'd2, 2'd3);
    tick(); idle(); use_rs1_i = 1; rs1_i = 5'd2;
    tick();
    check("sat_no_wrap", {16'd0, stall_cnt_o}, 32'h0000_FFFF);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 SHALL expose these ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- issue_valid_i  in  1  ID instruction is advancing to EX this cycle.
- issue_regwrite_i  in  1  issuing instruction writes rd.
- issue_rd_i  in  5  destination register of issuing instruction.
- issue_lat_i  in  2  extra cycles before result is forwardable: 0 = ALU, 1 = load, 2–3 = multi-cycle unit.
- rs1_i  in  5  source register 1 of the instruction in ID.
- rs2_i  in  5  source register 2 of the instruction in ID.
- use_rs1_i  in  1  ID instruction reads rs1.
- use_rs2_i  in  1  ID instruction reads rs2.
- wb_valid_i  in  1  writeback stage commits a register write.
- wb_rd_i  in  5  register being written back.
- flush_i  in  1  ID instruction is squashed this cycle.
- stall_o  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- rs1_busy_o  out  1  rs1 operand not yet forwardable.
- rs2_busy_o  out  1  rs2 operand not yet forwardable.
- pending_o  out  32  per-register in-flight (busy) bit; bit 0 is always 0.
- stall_cnt_o  out  16  saturating count of stall cycles.

Function
REQ-003 SHALL hold, per register r = 1..31, a busy bit busy[r] and a 2-bit countdown cnt[r]; register 0 SHALL never be tracked.
REQ-004 rs1_busy_o SHALL equal use_rs1_i AND (rs1_i != 0) AND busy[rs1_i] AND (cnt[rs1_i] != 0), evaluated combinationally from registered state.
REQ-005 rs2_busy_o SHALL be defined identically using rs2 signals.
REQ-006 stall_o SHALL equal (rs1_busy_o OR rs2_busy_o) AND NOT flush_i.
REQ-007 An issue SHALL be accepted iff issue_valid_i AND issue_regwrite_i AND (issue_rd_i != 0) AND NOT stall_o AND NOT flush_i.
REQ-008 An accepted issue SHALL set busy[issue_rd_i] <= 1 and cnt[issue_rd_i] <= issue_lat_i at the next edge.
REQ-009 Each cycle, every other register with cnt != 0 SHALL decrement cnt by 1; cnt SHALL saturate at 0 and never wrap.
REQ-010 Writeback (wb_valid_i AND wb_rd_i != 0) SHALL clear busy[wb_rd_i] and cnt[wb_rd_i] at the next edge.
REQ-011 If an accepted issue and a writeback target the same register in the same cycle, the issue SHALL win: busy stays 1 and cnt is loaded.
REQ-012 Re-issue to a register that is already busy SHALL overwrite cnt with the new issue_lat_i; no decrement applies that cycle.
REQ-013 Latency: a source with cnt = k at issue time SHALL stall a dependent instruction in the immediately following ID cycle for exactly k cycles, with no other events; a load therefore costs 1 stall.
REQ-014 pending_o[r] SHALL equal busy[r]; pending_o[0] SHALL be 0.
REQ-015 stall_cnt_o SHALL increment on each edge where stall_o = 1 and SHALL saturate at 16'hFFFF.
REQ-016 Busy registers with cnt = 0 SHALL NOT stall; the forwarding path covers them.

Reset
REQ-017 While rst_i = 1, irrespective of clk_i, all busy bits, all cnt values, and stall_cnt_o SHALL be 0, and therefore stall_o, rs1_busy_o, rs2_busy_o and pending_o SHALL be 0.
REQ-018 Reset asserted mid-stall SHALL drop stall_o immediately (asynchronously), discarding all in-flight state.
REQ-019 The first edge after rst_i deasserts SHALL behave as a normal cycle.

Verification
REQ-020 Load-use: issue rd = 5 with lat = 1; next cycle rs1 = 5, use_rs1 = 1 -> stall_o = 1 for exactly 1 cycle, then 0; stall_cnt_o = 1.
REQ-021 ALU dependency: issue rd = 7 with lat = 0; next cycle rs2 = 7 -> stall_o = 0 and pending_o[7] = 1 until wb_rd = 7 clears it.
REQ-022 Multi-cycle op: issue rd = 9 with lat = 3; rs1 = rs2 = 9 held -> stall_o = 1 for 3 cycles; no second issue is accepted during the stall.
REQ-023 Collision and x0: same-cycle accepted issue rd = 4 and wb_rd = 4 -> pending_o[4] stays 1; issue rd = 0 with lat = 3 -> pending_o = 0 and no stall on rs1 = 0.
REQ-024 Flush and reset: flush_i = 1 while a hazard exists -> stall_o = 0 and the issue is not recorded; rst_i pulsed during a lat = 3 stall -> stall_o falls without a clock edge and pending_o = 0.
REQ-025 Saturation: force 65 540 consecutive stall cycles -> stall_cnt_o holds 16'hFFFF.
